control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
Multi-cycle control unit that drives datapath_core.
- Reads the instruction register (IR_Out) and status flags (SF).
- Sequences FETCH/EXECUTE/MEM/BRANCH states, producing the full control word (AS, DS, PS, PC_Sel, K_Sel, IL, SL, FS, C0, MW, RW, DA, SA, SB, K) every cycle.
- Replaces the hand-driven control words in datapath-level benches.
- Covers a LEGv8 subset: R-type, I-type, LDUR/STUR, B, CBZ/CBNZ; any other opcode halts.

Parameters:
DATA_W, 64, width of the K constant output
IR_W, 32, instruction width

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
IR  in  32  instruction register contents from datapath (IR_Out)
SF  in  4  registered status flags {V,C,N,Z}; SF[0]=Z
AS  out  1  address select: 1=PC drives address, 0=ALU result
DS  out  3  data-bus select: 000 ALU, 001 RAM, 010 PC, 011 ROM
PS  out  2  PC op: 00 hold, 01 PC+4, 10 load A, 11 PC+K
PC_Sel  out  1  PC load source (0=K path, 1=reg A); driven 0 when unused
K_Sel  out  1  ALU B source: 1=K, 0=reg B
IL  out  1  instruction register load
SL  out  1  status flag load
FS  out  5  ALU function (package codes; ADD=01000)
C0  out  1  ALU carry-in
MW  out  1  memory write
RW  out  1  register file write
DA/SA/SB  out  5 each  destination / source A / source B register
K  out  DATA_W  sign-extended constant
halted  out  1  high in HALT state
state  out  3  current state (debug)

Behaviour:
- States: FETCH, EXEC, MEM, BRANCH, HALT. Outputs are a Moore/Mealy combination of state and decoded IR; no output registers.
- Reset (rst=0, async): state←FETCH. While rst=0, force RW=MW=IL=SL=0, PS=00, halted=0, all other outputs 0.
- Inactive default every cycle: RW=MW=IL=SL=0, PS=00, C0=0, PC_Sel=0, K=0.
- FETCH: AS=1, DS=011, PS=01, IL=1, RW=0, MW=0 → next EXEC. One cycle.
- EXEC decode (IR fields: Rd[4:0], Rn[9:5], Rm[20:16], imm12[21:10], dt9[20:12], br26[25:0], cb19[23:5]):
  - R-type ADD/SUB/AND/ORR/EOR: SA=Rn, SB=Rm, K_Sel=0, DA=Rd, DS=000, RW=1. SUB uses FS=SUB with C0=1. → FETCH.
  - I-type ADDI/SUBI/ANDI/ORRI: SA=Rn, K=zext(imm12), K_Sel=1, DA=Rd, DS=000, RW=1. → FETCH.
  - LDUR: AS=0, SA=Rn, K=sext(dt9), K_Sel=1, FS=ADD, RW=0. → MEM.
  - STUR: AS=0, SA=Rn, SB=Rd(Rt), K=sext(dt9), K_Sel=1, FS=ADD, MW=1. → FETCH.
  - B: PS=11, K=sext(br26)·4−4 (PC already advanced by 4). → FETCH.
  - CBZ/CBNZ: SA=Rt, K=0, K_Sel=1, FS=ADD, SL=1. → BRANCH.
  - Unknown opcode: all writes 0. → HALT.
- MEM (LDUR, second cycle): address controls held as in EXEC, DS=001, DA=Rt, RW=1. → FETCH. Total 3 cycles including fetch.
- BRANCH: K=sext(cb19)·4−4. PS=11 when taken, else PS=00. Taken = (CBZ & SF[0]) | (CBNZ & ~SF[0]), evaluated on flags latched in EXEC. → FETCH.
- HALT: absorbing state; only reset exits. halted=1, all writes 0.
- Opcode match is exact on the class-specific field width. CBZ/CBNZ match is checked before the B test.
- Reset asserted mid-instruction aborts immediately; no partial write is completed after rst rises.

Decomposition:
- Package cu_pkg: state enum; FS codes (AND 00000, OR 00100, ADD 01000, SUB 01001, XOR 01100); DS and PS codes; LEGv8 opcode constants; instruction-class enum.
- Sub-module cu_decoder: combinational IR → instruction class plus extracted and sign-extended fields. The FSM and output mux stay in control_unit.

Test Plan:
- Reset: hold rst=0 at arbitrary IR → RW=MW=IL=SL=0, PS=00. Release → FETCH outputs: AS=1, DS=011, PS=01, IL=1.
- ADDI X2,X31,#7 (IR=0x910_01FE2): EXEC → K=7, SA=31, DA=2, FS=01000, K_Sel=1, RW=1, DS=000. Next cycle FETCH.
- SUB X3,X1,X2: EXEC → SA=1, SB=2, DA=3, FS=SUB, C0=1, K_Sel=0, RW=1.
- LDUR X5,[X4,#-8]: EXEC → AS=0, K=0xFFFF_FFFF_FFFF_FFF8, RW=0. MEM → DS=001, DA=5, RW=1. Then FETCH.
- CBZ X1,+3: with SF[0]=1 → BRANCH PS=11, K=8. With SF[0]=0 → PS=00. CBNZ gives the inverse.
- Illegal IR=0x0000_0000 → HALT, halted=1, stays for ≥10 cycles. rst=0 → FETCH.

Source files
------------

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared types and encodings for the LEGv8 control unit
package cu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC   = 3'd1,
    S_MEM    = 3'd2,
    S_BRANCH = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_I, C_LDUR, C_STUR, C_B, C_CBZ, C_CBNZ, C_ILL
  } cls_e;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_XOR = 5'b01100;

  localparam logic [2:0] DS_ALU = 3'b000;
  localparam logic [2:0] DS_RAM = 3'b001;
  localparam logic [2:0] DS_ROM = 3'b011;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_ADDK = 2'b11;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;

endpackage

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - combinational instruction classifier and field extractor
module cu_decoder
  import cu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [31:0]       ir_i,
  output cls_e              cls_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rn_o,
  output logic [4:0]        rm_o,
  output logic [4:0]        fs_o,
  output logic              c0_o,
  output logic [DATA_W-1:0] k_imm_o,
  output logic [DATA_W-1:0] k_dt_o,
  output logic [DATA_W-1:0] k_br_o,
  output logic [DATA_W-1:0] k_cb_o
);

  assign rd_o = ir_i[4:0];
  assign rn_o = ir_i[9:5];
  assign rm_o = ir_i[20:16];

  // Branch offsets are pre-reduced by 4 because the PC already advanced in FETCH
  assign k_imm_o = {{(DATA_W-12){1'b0}}, ir_i[21:10]};
  assign k_dt_o  = {{(DATA_W-9){ir_i[20]}}, ir_i[20:12]};
  assign k_br_o  = {{(DATA_W-28){ir_i[25]}}, ir_i[25:0], 2'b00} - DATA_W'(4);
  assign k_cb_o  = {{(DATA_W-21){ir_i[23]}}, ir_i[23:5], 2'b00} - DATA_W'(4);

  always_comb begin
    cls_o = C_ILL;
    fs_o  = FS_ADD;
    c0_o  = 1'b0;
    if (ir_i[31:24] == OP_CBZ) begin
      cls_o = C_CBZ;
    end else if (ir_i[31:24] == OP_CBNZ) begin
      cls_o = C_CBNZ;
    end else if (ir_i[31:26] == OP_B) begin
      cls_o = C_B;
    end else if (ir_i[31:21] == OP_LDUR) begin
      cls_o = C_LDUR;
    end else if (ir_i[31:21] == OP_STUR) begin
      cls_o = C_STUR;
    end else begin
      case (ir_i[31:21])
        OP_ADD:  begin cls_o = C_R; fs_o = FS_ADD; end
        OP_SUB:  begin cls_o = C_R; fs_o = FS_SUB; c0_o = 1'b1; end
        OP_AND:  begin cls_o = C_R; fs_o = FS_AND; end
        OP_ORR:  begin cls_o = C_R; fs_o = FS_OR;  end
        OP_EOR:  begin cls_o = C_R; fs_o = FS_XOR; end
        default: begin
          case (ir_i[31:22])
            OP_ADDI: begin cls_o = C_I; fs_o = FS_ADD; end
            OP_SUBI: begin cls_o = C_I; fs_o = FS_SUB; c0_o = 1'b1; end
            OP_ANDI: begin cls_o = C_I; fs_o = FS_AND; end
            OP_ORRI: begin cls_o = C_I; fs_o = FS_OR;  end
            default: cls_o = C_ILL;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle LEGv8 control FSM producing the datapath control word
module control_unit
  import cu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int IR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IR_W-1:0]   IR,
  input  logic [3:0]        SF,
  output logic              AS,
  output logic [2:0]        DS,
  output logic [1:0]        PS,
  output logic              PC_Sel,
  output logic              K_Sel,
  output logic              IL,
  output logic              SL,
  output logic [4:0]        FS,
  output logic              C0,
  output logic              MW,
  output logic              RW,
  output logic [4:0]        DA,
  output logic [4:0]        SA,
  output logic [4:0]        SB,
  output logic [DATA_W-1:0] K,
  output logic              halted,
  output logic [2:0]        state
);

  state_e              state_q, state_d;
  cls_e                cls;
  logic [4:0]          rd, rn, rm, dec_fs;
  logic                dec_c0, taken;
  logic [DATA_W-1:0]   k_imm, k_dt, k_br, k_cb;
  logic                unused_sf;

  cu_decoder #(.DATA_W(DATA_W)) u_dec (
    .ir_i    (IR[31:0]),
    .cls_o   (cls),
    .rd_o    (rd),
    .rn_o    (rn),
    .rm_o    (rm),
    .fs_o    (dec_fs),
    .c0_o    (dec_c0),
    .k_imm_o (k_imm),
    .k_dt_o  (k_dt),
    .k_br_o  (k_br),
    .k_cb_o  (k_cb)
  );

  assign unused_sf = ^SF[3:1];
  assign taken     = ((cls == C_CBZ) & SF[0]) | ((cls == C_CBNZ) & ~SF[0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    AS = 1'b0; DS = DS_ALU; PS = PS_HOLD; PC_Sel = 1'b0; K_Sel = 1'b0;
    IL = 1'b0; SL = 1'b0; FS = FS_AND; C0 = 1'b0; MW = 1'b0; RW = 1'b0;
    DA = '0; SA = '0; SB = '0; K = '0;
    unique case (state_q)
      S_FETCH: begin
        AS = 1'b1; DS = DS_ROM; PS = PS_INC; IL = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (cls)
          C_R:    begin SA = rn; SB = rm; DA = rd; FS = dec_fs; C0 = dec_c0; RW = 1'b1; end
          C_I:    begin SA = rn; K = k_imm; K_Sel = 1'b1; DA = rd; FS = dec_fs; C0 = dec_c0; RW = 1'b1; end
          C_LDUR: begin SA = rn; K = k_dt; K_Sel = 1'b1; FS = FS_ADD; state_d = S_MEM; end
          C_STUR: begin SA = rn; SB = rd; K = k_dt; K_Sel = 1'b1; FS = FS_ADD; MW = 1'b1; end
          C_B:    begin PS = PS_ADDK; K = k_br; end
          C_CBZ, C_CBNZ: begin
            SA = rd; K_Sel = 1'b1; FS = FS_ADD; SL = 1'b1;
            state_d = S_BRANCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        SA = rn; K = k_dt; K_Sel = 1'b1; FS = FS_ADD;
        DS = DS_RAM; DA = rd; RW = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        K = k_cb;
        if (taken) PS = PS_ADDK;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Outputs are combinational, so reset must mask them directly
    if (!rst) begin
      AS = 1'b0; DS = DS_ALU; PS = PS_HOLD; PC_Sel = 1'b0; K_Sel = 1'b0;
      IL = 1'b0; SL = 1'b0; FS = FS_AND; C0 = 1'b0; MW = 1'b0; RW = 1'b0;
      DA = '0; SA = '0; SB = '0; K = '0;
    end
  end

  assign halted = rst & (state_q == S_HALT);
  assign state  = state_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed bench for control_unit
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR;
  logic [3:0]  SF;
  logic        AS, PC_Sel, K_Sel, IL, SL, C0, MW, RW, halted;
  logic [2:0]  DS, state;
  logic [1:0]  PS;
  logic [4:0]  FS, DA, SA, SB;
  logic [63:0] K;
  int total = 0;
  int bad   = 0;

  control_unit #(.DATA_W(64), .IR_W(32)) dut (
    .clk(clk), .rst(rst), .IR(IR), .SF(SF),
    .AS(AS), .DS(DS), .PS(PS), .PC_Sel(PC_Sel), .K_Sel(K_Sel),
    .IL(IL), .SL(SL), .FS(FS), .C0(C0), .MW(MW), .RW(RW),
    .DA(DA), .SA(SA), .SB(SB), .K(K), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Called while in FETCH: present the instruction and advance into EXEC
  task automatic fetch(input logic [31:0] instr);
    check("fetch_il", IL, 1);
    check("fetch_state", state, 0);
    IR = instr;
    step();
  endtask

  initial begin
    rst = 1'b0; IR = 32'hDEADBEEF; SF = 4'hF;
    step(); step();
    check("rst_rw", RW, 0); check("rst_mw", MW, 0); check("rst_il", IL, 0);
    check("rst_sl", SL, 0); check("rst_ps", PS, 0); check("rst_as", AS, 0);
    check("rst_state", state, 0); check("rst_halted", halted, 0);

    rst = 1'b1; #1;
    check("fetch_as", AS, 1); check("fetch_ds", DS, 3); check("fetch_ps", PS, 1);

    // ADDI X2,X31,#7
    fetch(32'h91001FE2);
    check("addi_state", state, 1); check("addi_k", K, 7); check("addi_sa", SA, 31);
    check("addi_da", DA, 2); check("addi_fs", FS, 5'b01000); check("addi_ksel", K_Sel, 1);
    check("addi_rw", RW, 1); check("addi_ds", DS, 0);
    step();

    // SUB X3,X1,X2
    fetch(32'hCB020023);
    check("sub_sa", SA, 1); check("sub_sb", SB, 2); check("sub_da", DA, 3);
    check("sub_fs", FS, 5'b01001); check("sub_c0", C0, 1); check("sub_ksel", K_Sel, 0);
    check("sub_rw", RW, 1);
    step();

    // LDUR X5,[X4,#-8]
    fetch(32'hF85F8085);
    check("ldur_as", AS, 0); check("ldur_k", K, 64'hFFFF_FFFF_FFFF_FFF8);
    check("ldur_rw", RW, 0); check("ldur_sa", SA, 4);
    step();
    check("mem_state", state, 2); check("mem_ds", DS, 1); check("mem_da", DA, 5);
    check("mem_rw", RW, 1); check("mem_as", AS, 0);
    step();

    // STUR X6,[X7,#16]
    fetch(32'hF80100E6);
    check("stur_mw", MW, 1); check("stur_sa", SA, 7); check("stur_sb", SB, 6);
    check("stur_k", K, 16); check("stur_rw", RW, 0);
    step();

    // B +5
    fetch(32'h14000005);
    check("b_ps", PS, 3); check("b_k", K, 16);
    step();

    // CBZ X1,+3 taken
    fetch(32'hB4000061);
    check("cbz_sl", SL, 1); check("cbz_sa", SA, 1); check("cbz_ksel", K_Sel, 1);
    check("cbz_fs", FS, 5'b01000);
    SF = 4'b0001;
    step();
    check("cbz_t_state", state, 3); check("cbz_t_ps", PS, 3); check("cbz_t_k", K, 8);
    step();

    // CBZ not taken
    fetch(32'hB4000061);
    SF = 4'b0000;
    step();
    check("cbz_nt_ps", PS, 0);
    step();

    // CBNZ taken, not taken
    fetch(32'hB5000061);
    SF = 4'b0000;
    step();
    check("cbnz_t_ps", PS, 3);
    step();
    fetch(32'hB5000061);
    SF = 4'b0001;
    step();
    check("cbnz_nt_ps", PS, 0);
    step();

    // CBNZ -2: K = -8 - 4
    fetch(32'hB5FFFFC1);
    SF = 4'b0000;
    step();
    check("cbnz_neg_k", K, 64'hFFFF_FFFF_FFFF_FFF4); check("cbnz_neg_ps", PS, 3);
    step();

    // Reset mid-LDUR aborts the load
    fetch(32'hF85F8085);
    rst = 1'b0; #1;
    check("abort_state", state, 0); check("abort_rw", RW, 0);
    step();
    check("abort_rw2", RW, 0);
    rst = 1'b1; #1;
    check("abort_il", IL, 1);

    // Illegal opcode halts until reset
    fetch(32'h0000_0000);
    check("ill_rw", RW, 0); check("ill_mw", MW, 0); check("ill_halted", halted, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_halted", halted, 1);
      check("halt_state", state, 4);
    end
    check("halt_il", IL, 0);
    rst = 1'b0; #1;
    check("halt_rst_state", state, 0); check("halt_rst_halted", halted, 0);
    step();
    rst = 1'b1; #1;
    check("post_halt_il", IL, 1); check("post_halt_as", AS, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
